// File: rtl/app_regs_if.sv
// Byte-stream handshake bundle between the usb_cdc application side and app_regs.
// Signal names are written from the app_regs point of view; the slave modport is app_regs.
interface app_regs_if;
  logic [7:0] out_data_i;
  logic       out_valid_i;
  logic       out_ready_o;
  logic [7:0] in_data_o;
  logic       in_valid_o;
  logic       in_ready_i;

  modport slave (
    input  out_data_i,
    input  out_valid_i,
    output out_ready_o,
    output in_data_o,
    output in_valid_o,
    input  in_ready_i
  );

  modport master (
    output out_data_i,
    output out_valid_i,
    input  out_ready_o,
    input  in_data_o,
    input  in_valid_o,
    output in_ready_i
  );
endinterface

// File: rtl/app_regs.sv
// ASCII command parser ("Wadd"/"Ra") over a byte stream, backed by a 16 x 8-bit register file.
// Optional idle/sleep detector enabled by defining APP_REGS_SLEEP_EN.
module app_regs #(
  parameter logic [23:0] SLEEP_CYCLES = 24'd12000000
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  app_regs_if.slave  bus,
  output logic       sleep_o
);

  typedef enum logic [2:0] {StIdle, StAddr, StDataH, StDataL, StResp} state_e;

  state_e     state_q, state_d;
  logic       rdy_q;
  logic [7:0] regs_q [16];
  logic       op_wr_q, op_wr_d;
  logic [3:0] addr_q, addr_d;
  logic [3:0] hi_q, hi_d;
  logic [7:0] rsp_q [4];
  logic [7:0] rsp_d [4];
  logic [1:0] last_q, last_d;
  logic [1:0] idx_q, idx_d;
  logic       wr_en;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       out_xfer, in_xfer;
  logic       is_hex_c;
  logic [3:0] hex_v;

  function automatic logic is_hex(input logic [7:0] c);
    return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) ||
           (c >= 8'h61 && c <= 8'h66);
  endfunction

  // 'A'/'a' have low nibble 1, so adding 9 maps them to 10.
  function automatic logic [3:0] hex_val(input logic [7:0] c);
    return (c <= 8'h39) ? c[3:0] : c[3:0] + 4'd9;
  endfunction

  function automatic logic [7:0] hex_chr(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  assign out_xfer = bus.out_valid_i & bus.out_ready_o;
  assign in_xfer  = bus.in_valid_o & bus.in_ready_i;
  assign is_hex_c = is_hex(bus.out_data_i);
  assign hex_v    = hex_val(bus.out_data_i);
  assign rd_data  = regs_q[hex_v];
  assign wr_data  = {hi_q, hex_v};

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= StIdle;
      rdy_q   <= 1'b0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      hi_q    <= '0;
      last_q  <= '0;
      idx_q   <= '0;
      for (int i = 0; i < 4; i++) rsp_q[i] <= '0;
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      hi_q    <= hi_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      rsp_q   <= rsp_d;
      if (wr_en) regs_q[addr_q] <= wr_data;
    end
  end

  always_comb begin
    state_d = state_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    hi_d    = hi_q;
    rsp_d   = rsp_q;
    last_d  = last_q;
    idx_d   = idx_q;
    wr_en   = 1'b0;
    // Any protocol error collapses to a single "?" reply; overridden below on valid paths.
    if (out_xfer && state_q != StResp) begin
      rsp_d[0] = 8'h3F;
      last_d   = 2'd0;
      idx_d    = 2'd0;
      state_d  = StResp;
    end
    unique case (state_q)
      StIdle: begin
        if (out_xfer) begin
          if (bus.out_data_i == 8'h57 || bus.out_data_i == 8'h77) begin
            op_wr_d = 1'b1;
            state_d = StAddr;
          end else if (bus.out_data_i == 8'h52 || bus.out_data_i == 8'h72) begin
            op_wr_d = 1'b0;
            state_d = StAddr;
          end else if (bus.out_data_i == 8'h0D || bus.out_data_i == 8'h0A) begin
            state_d = StIdle;
          end
        end
      end
      StAddr: begin
        if (out_xfer && is_hex_c) begin
          if (op_wr_q) begin
            addr_d  = hex_v;
            state_d = StDataH;
          end else begin
            rsp_d[0] = hex_chr(rd_data[7:4]);
            rsp_d[1] = hex_chr(rd_data[3:0]);
            rsp_d[2] = 8'h0D;
            rsp_d[3] = 8'h0A;
            last_d   = 2'd3;
          end
        end
      end
      StDataH: begin
        if (out_xfer && is_hex_c) begin
          hi_d    = hex_v;
          state_d = StDataL;
        end
      end
      StDataL: begin
        if (out_xfer && is_hex_c) begin
          wr_en    = 1'b1;
          rsp_d[0] = 8'h2B;
        end
      end
      StResp: begin
        if (in_xfer) begin
          if (idx_q == last_q) begin
            idx_d   = 2'd0;
            state_d = StIdle;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.out_ready_o = rdy_q & (state_q != StResp);
    bus.in_valid_o  = (state_q == StResp);
    bus.in_data_o   = (state_q == StResp) ? rsp_q[idx_q] : 8'h00;
  end

`ifdef APP_REGS_SLEEP_EN
  logic [23:0] idle_q, idle_d;

  always_comb begin
    idle_d = idle_q;
    if (out_xfer || in_xfer) begin
      idle_d = '0;
    end else if (idle_q != SLEEP_CYCLES) begin
      idle_d = idle_q + 24'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) idle_q <= '0;
    else         idle_q <= idle_d;
  end

  assign sleep_o = (idle_q == SLEEP_CYCLES);
`else
  logic unused_sleep_cycles;
  assign unused_sleep_cycles = ^SLEEP_CYCLES;
  assign sleep_o = 1'b0;
`endif

endmodule

// File: tb/tb_app_regs.sv
// Directed bench for app_regs: command/reply sequences, back-pressure, reset abort, sleep.
module tb_app_regs;

  logic clk = 1'b0;
  logic rstn;
  logic sleep;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  app_regs_if bus ();

  app_regs #(
    .SLEEP_CYCLES (24'd100)
  ) dut (
    .clk_i   (clk),
    .rstn_i  (rstn),
    .bus     (bus),
    .sleep_o (sleep)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    bus.out_data_i  = b;
    bus.out_valid_i = 1'b1;
    while (bus.out_ready_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("out_ready_timeout", {31'd0, bus.out_ready_o}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.out_valid_i = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  // Expects the reply to be presented immediately and stream with no bubbles.
  task automatic recv(input string tag, input logic [31:0] exp, input int len);
    bus.in_ready_i = 1'b1;
    for (int i = 0; i < len; i++) begin
      chk({tag, "_valid"}, {31'd0, bus.in_valid_o}, 32'd1);
      chk({tag, "_data"}, {24'd0, bus.in_data_o}, {24'd0, exp[31-8*i -: 8]});
      @(posedge clk);
      @(negedge clk);
    end
    chk({tag, "_end"}, {31'd0, bus.in_valid_o}, 32'd0);
    chk({tag, "_idle"}, {31'd0, bus.out_ready_o}, 32'd1);
    bus.in_ready_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn            = 1'b0;
    bus.out_data_i  = 8'h00;
    bus.out_valid_i = 1'b0;
    bus.in_ready_i  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_ready", {31'd0, bus.out_ready_o}, 32'd0);
    chk("rst_in_valid", {31'd0, bus.in_valid_o}, 32'd0);
    chk("rst_in_data", {24'd0, bus.in_data_o}, 32'h00);
    chk("rst_sleep", {31'd0, sleep}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, bus.out_ready_o}, 32'd1);

    // Write then read back.
    send_str("W3A5");
    recv("w3a5", 32'h2B000000, 1);
    send_str("R3");
    recv("r3", 32'h41350D0A, 4);

    // Lower-case command and digits.
    send_str("w0ff");
    recv("w0ff", 32'h2B000000, 1);
    send_str("r0");
    recv("r0", 32'h46460D0A, 4);

    // Bad digit aborts the write.
    send_str("W1G");
    recv("w1g", 32'h3F000000, 1);
    send_str("R1");
    recv("r1", 32'h30300D0A, 4);

    // Bad low digit aborts as well.
    send_str("W2Az");
    recv("w2az", 32'h3F000000, 1);
    send_str("R2");
    recv("r2", 32'h30300D0A, 4);

    // CR/LF ignored, unknown command rejected.
    send(8'h0D);
    chk("cr_no_reply", {31'd0, bus.in_valid_o}, 32'd0);
    send(8'h0A);
    chk("lf_no_reply", {31'd0, bus.in_valid_o}, 32'd0);
    send(8'h78);
    recv("bad_cmd", 32'h3F000000, 1);

    // Back-pressure holds the first reply byte.
    send_str("R3");
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", {31'd0, bus.in_valid_o}, 32'd1);
      chk("bp_data", {24'd0, bus.in_data_o}, 32'h41);
      chk("bp_out_ready", {31'd0, bus.out_ready_o}, 32'd0);
      @(negedge clk);
    end
    recv("bp_r3", 32'h41350D0A, 4);

    // Reset in the middle of a reply.
    send_str("R3");
    bus.in_ready_i = 1'b1;
    chk("ab_b0", {24'd0, bus.in_data_o}, 32'h41);
    @(posedge clk);
    @(negedge clk);
    chk("ab_b1", {24'd0, bus.in_data_o}, 32'h35);
    @(posedge clk);
    @(negedge clk);
    bus.in_ready_i = 1'b0;
    rstn = 1'b0;
    #1;
    chk("ab_in_valid", {31'd0, bus.in_valid_o}, 32'd0);
    chk("ab_in_data", {24'd0, bus.in_data_o}, 32'h00);
    chk("ab_out_ready", {31'd0, bus.out_ready_o}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    send_str("R3");
    recv("ab_r3", 32'h30300D0A, 4);

    // Idle detector from a fresh reset.
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (99) @(negedge clk);
    chk("sleep_99", {31'd0, sleep}, 32'd0);
    @(negedge clk);
`ifdef APP_REGS_SLEEP_EN
    chk("sleep_100", {31'd0, sleep}, 32'd1);
    @(negedge clk);
    chk("sleep_hold", {31'd0, sleep}, 32'd1);
`else
    chk("sleep_off_100", {31'd0, sleep}, 32'd0);
    @(negedge clk);
    chk("sleep_off_hold", {31'd0, sleep}, 32'd0);
`endif
    send(8'h57);
    chk("sleep_wake", {31'd0, sleep}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
